// File: rtl/cube_group_packer.sv
// Rebuilds a 32-bit word from eleven 3-bit groups arriving MSB-first (group 0
// carries only two payload bits), then holds it until the consumer takes it.
// Handshake: a group moves when in_valid && in_ready; the word moves when out_valid && out_ready.
module cube_group_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [2:0]  grp,
  output logic        in_ready,
  output logic [31:0] word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  idx,
  output logic        fmt_err
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_FULL    = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd10;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        fmt_err_q, fmt_err_d;
  logic        out_valid_q, out_valid_d;
  logic        accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      idx_q       <= 4'd0;
      word_q      <= 32'd0;
      fmt_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      fmt_err_q   <= fmt_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: if (accept && idx_q == LAST_IDX) state_d = S_FULL;
        S_FULL:    if (out_ready) state_d = S_COLLECT;
        default:   state_d = S_COLLECT;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == S_COLLECT);
  end

  // clear outranks the handshake, so a group offered alongside it is dropped.
  assign accept = in_valid && in_ready && !clear;

  always_comb begin
    idx_d       = idx_q;
    word_d      = word_q;
    fmt_err_d   = fmt_err_q;
    out_valid_d = (state_d == S_FULL);
    if (clear) begin
      idx_d     = 4'd0;
      word_d    = 32'd0;
      fmt_err_d = 1'b0;
    end else if (accept) begin
      if (idx_q == 4'd0) begin
        word_d    = {30'd0, grp[1:0]};
        fmt_err_d = grp[2];
        idx_d     = 4'd1;
      end else begin
        word_d = {word_q[28:0], grp};
        idx_d  = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
      end
    end
  end

  assign word      = word_q;
  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_cube_group_packer.sv
// Bench for cube_group_packer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the accepted groups.
module tb_cube_group_packer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [2:0]  grp;
  logic        in_ready;
  logic [31:0] word;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  idx;
  logic        fmt_err;

  int checks;
  int errors;

  // Reference model: the groups of the word in progress, plus the held result.
  int unsigned mg[$];
  logic        m_full;
  logic [31:0] m_word;
  logic        m_fmt;

  cube_group_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .grp       (grp),
    .in_ready  (in_ready),
    .word      (word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .fmt_err   (fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Partial word value: group 0 contributes its low two bits, every later
  // group three bits, most significant first.
  function automatic logic [31:0] model_value();
    longint unsigned w;
    int n;
    w = 0;
    n = mg.size();
    for (int i = 0; i < n; i++) begin
      longint unsigned v;
      v = (i == 0) ? longint'(mg[i] % 4) : longint'(mg[i]);
      w = w + v * (longint'(1) << (3 * (n - 1 - i)));
    end
    return w[31:0];
  endfunction

  task automatic model_reset();
    mg.delete();
    m_full = 1'b0;
    m_word = 32'd0;
    m_fmt  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] g, input logic ordy, input logic clr);
    if (clr) begin
      model_reset();
    end else if (m_full) begin
      if (ordy) m_full = 1'b0;
    end else if (v) begin
      mg.push_back(int'(g));
      if (mg.size() == 1) m_fmt = g[2];
      m_word = model_value();
      if (mg.size() == 11) begin
        m_full = 1'b1;
        mg.delete();
      end
    end
  endtask

  task automatic check_all();
    chk("idx", {28'd0, idx}, mg.size());
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_full});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
    chk("word", word, m_word);
    chk("fmt_err", {31'd0, fmt_err}, {31'd0, m_fmt});
  endtask

  task automatic cyc(input logic v, input logic [2:0] g, input logic ordy, input logic clr);
    in_valid  = v;
    grp       = g;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    model_step(v, g, ordy, clr);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_word(input int unsigned g0, input int unsigned rest, input bit rnd);
    cyc(1'b1, g0[2:0], 1'b0, 1'b0);
    for (int k = 1; k < 11; k++) begin
      int unsigned g;
      g = rnd ? $urandom_range(0, 7) : rest;
      cyc(1'b1, g[2:0], 1'b0, 1'b0);
    end
  endtask

  initial begin
    int unsigned seq30[11];
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    grp       = 3'd0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    do_reset();

    // All-ones word, consumer always ready: out_valid high for one cycle.
    cyc(1'b1, 3'd3, 1'b1, 1'b0);
    for (int k = 1; k < 11; k++) cyc(1'b1, 3'd7, 1'b1, 1'b0);
    chk("ones_word", word, 32'hFFFF_FFFF);
    chk("ones_fmt", {31'd0, fmt_err}, 32'd0);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);
    chk("ones_valid_drop", {31'd0, out_valid}, 32'd0);

    // 0x12345678 with random idle gaps.
    seq30 = '{0, 2, 2, 1, 5, 0, 5, 3, 1, 7, 0};
    for (int k = 0; k < 11; k++) begin
      int unsigned gaps;
      gaps = $urandom_range(0, 2);
      for (int j = 0; j < int'(gaps); j++) cyc(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      chk("seq_idx", {28'd0, idx}, k);
      cyc(1'b1, seq30[k][2:0], 1'b0, 1'b0);
    end
    chk("seq_word", word, 32'h1234_5678);
    chk("seq_idx_wrap", {28'd0, idx}, 32'd0);

    // Back-pressure: five stalled cycles with groups offered, then release
    // with a group offered in the same cycle.
    for (int j = 0; j < 5; j++) cyc(1'b1, 3'd5, 1'b0, 1'b0);
    chk("stall_word", word, 32'h1234_5678);
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 3'd6, 1'b1, 1'b0);
    chk("release_idx", {28'd0, idx}, 32'd0);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    send_word(1, 0, 1'b1);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Format error flag follows group 0 bit 2.
    send_word(7, 0, 1'b0);
    chk("fmt_word", word, 32'hC000_0000);
    chk("fmt_set", {31'd0, fmt_err}, 32'd1);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);
    send_word(1, 0, 1'b1);
    chk("fmt_clear", {31'd0, fmt_err}, 32'd0);
    cyc(1'b0, 3'd0, 1'b1, 1'b0);

    // Aborts: clear after 6 groups, reset after 4, then an all-zero word.
    for (int k = 0; k < 6; k++) cyc(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    cyc(1'b1, 3'd7, 1'b0, 1'b1);
    chk("clear_idx", {28'd0, idx}, 32'd0);
    chk("clear_word", word, 32'd0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    do_reset();
    chk("reset_idx", {28'd0, idx}, 32'd0);
    send_word(0, 0, 1'b0);
    chk("zero_word", word, 32'd0);
    chk("zero_valid", {31'd0, out_valid}, 32'd1);

    // Clear while full.
    cyc(1'b0, 3'd0, 1'b0, 1'b1);
    chk("clear_full_valid", {31'd0, out_valid}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic v, ordy, clr;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 60) == 0);
      cyc(v, 3'($urandom_range(0, 7)), ordy, clr);
      if ($urandom_range(0, 150) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
